// File: rtl/dcpu16_opfetch.sv
// DCPU16 operand fetch unit: decodes NOPS operand specifiers, performs the
// next-word and memory reads over a handshaked read-only bus, and returns
// operand values, effective addresses, memory flags and the updated PC/SP.
module dcpu16_opfetch #(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int NOPS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [6*NOPS-1:0]    ea,
    input  logic [DW*NOPS-1:0]   rrd,
    input  logic [AW-1:0]        pc_in,
    input  logic [AW-1:0]        sp_in,
    input  logic [DW-1:0]        o_in,
    output logic [AW-1:0]        fb_adr,
    output logic                 fb_stb,
    output logic                 fb_wre,
    input  logic [DW-1:0]        fb_dti,
    input  logic                 fb_ack,
    output logic                 busy,
    output logic                 done,
    output logic [DW*NOPS-1:0]   opv,
    output logic [AW*NOPS-1:0]   opa,
    output logic [NOPS-1:0]      opm,
    output logic [AW-1:0]        pc_out,
    output logic [AW-1:0]        sp_out
);

    typedef enum logic [2:0] {IDLE, DECODE, NWRD, MEM, FIN} state_t;

    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [1:0]    K_LAST = 2'(NOPS - 1);

    // Width adaptation between the data and address domains
    function automatic logic [AW-1:0] to_aw(input logic [DW-1:0] d);
        return AW'(d);
    endfunction

    function automatic logic [DW-1:0] to_dw(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    state_t               state, state_n;
    logic [1:0]           k, k_n;
    logic [AW-1:0]        pc, pc_n, sp, sp_n, adr, adr_n;
    logic [6*NOPS-1:0]    ea_r;
    logic [DW*NOPS-1:0]   rrd_r;
    logic [DW-1:0]        o_r;
    logic [DW*NOPS-1:0]   opv_w, opv_n;
    logic [AW*NOPS-1:0]   opa_w, opa_n;
    logic [NOPS-1:0]      opm_w, opm_n;
    logic [5:0]           cur_ea;
    logic [DW-1:0]        cur_rrd;
    logic                 adv;
    logic                 bus_n;

    assign cur_ea  = ea_r[6*k +: 6];
    assign cur_rrd = rrd_r[DW*k +: DW];
    assign busy    = (state != IDLE);
    assign fb_wre  = 1'b0;
    assign bus_n   = (state_n == NWRD) || (state_n == MEM);

    // Next-state, working PC/SP/address and per-operand result computation
    always_comb begin
        state_n = state;
        k_n     = k;
        pc_n    = pc;
        sp_n    = sp;
        adr_n   = adr;
        opv_n   = opv_w;
        opa_n   = opa_w;
        opm_n   = opm_w;
        adv     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = DECODE;
                    k_n     = 2'd0;
                    pc_n    = pc_in;
                    sp_n    = sp_in;
                    opv_n   = '0;
                    opa_n   = '0;
                    opm_n   = '0;
                end
            end
            DECODE: begin
                if (cur_ea[5]) begin
                    // short literal 0..31
                    opv_n[DW*k +: DW] = {{(DW-5){1'b0}}, cur_ea[4:0]};
                    adv = 1'b1;
                end else if (cur_ea[4:3] == 2'b00) begin
                    opv_n[DW*k +: DW] = cur_rrd;
                    adv = 1'b1;
                end else if (cur_ea[4:3] == 2'b01) begin
                    adr_n   = to_aw(cur_rrd);
                    state_n = MEM;
                end else if (cur_ea[4:3] == 2'b10) begin
                    adr_n   = pc;
                    state_n = NWRD;
                end else begin
                    case (cur_ea[2:0])
                        3'd0: begin
                            adr_n   = sp;
                            sp_n    = sp + A_ONE;
                            state_n = MEM;
                        end
                        3'd1: begin
                            adr_n   = sp;
                            state_n = MEM;
                        end
                        3'd2: begin
                            sp_n    = sp - A_ONE;
                            adr_n   = sp - A_ONE;
                            state_n = MEM;
                        end
                        3'd3: begin
                            opv_n[DW*k +: DW] = to_dw(sp);
                            adv = 1'b1;
                        end
                        3'd4: begin
                            opv_n[DW*k +: DW] = to_dw(pc);
                            adv = 1'b1;
                        end
                        3'd5: begin
                            opv_n[DW*k +: DW] = o_r;
                            adv = 1'b1;
                        end
                        default: begin
                            adr_n   = pc;
                            state_n = NWRD;
                        end
                    endcase
                end
            end
            NWRD: begin
                if (fb_ack) begin
                    pc_n = pc + A_ONE;
                    if (cur_ea == 6'h1f) begin
                        opv_n[DW*k +: DW] = fb_dti;
                        adv = 1'b1;
                    end else if (cur_ea == 6'h1e) begin
                        adr_n   = to_aw(fb_dti);
                        state_n = MEM;
                    end else begin
                        adr_n   = to_aw(fb_dti) + to_aw(cur_rrd);
                        state_n = MEM;
                    end
                end
            end
            MEM: begin
                if (fb_ack) begin
                    opv_n[DW*k +: DW] = fb_dti;
                    opa_n[AW*k +: AW] = adr;
                    opm_n[k]          = 1'b1;
                    adv = 1'b1;
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (adv) begin
            if (k == K_LAST) begin
                state_n = FIN;
            end else begin
                k_n     = k + 2'd1;
                state_n = DECODE;
            end
        end
    end

    // Control state, bus request and published results
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= 2'd0;
            fb_stb <= 1'b0;
            fb_adr <= '0;
            done   <= 1'b0;
            opv    <= '0;
            opa    <= '0;
            opm    <= '0;
            pc_out <= '0;
            sp_out <= '0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            fb_stb <= bus_n;
            if (bus_n) fb_adr <= adr_n;
            done   <= (state_n == FIN);
            if (state_n == FIN) begin
                opv    <= opv_n;
                opa    <= opa_n;
                opm    <= opm_n;
                pc_out <= pc_n;
                sp_out <= sp_n;
            end
        end
    end

    // Working datapath registers and instruction capture
    always_ff @(posedge clk) begin
        pc    <= pc_n;
        sp    <= sp_n;
        adr   <= adr_n;
        opv_w <= opv_n;
        opa_w <= opa_n;
        opm_w <= opm_n;
        if (state == IDLE && start) begin
            ea_r  <= ea;
            rrd_r <= rrd;
            o_r   <= o_in;
        end
    end

endmodule

// File: tb/tb_dcpu16_opfetch.sv
// Directed self-checking bench for dcpu16_opfetch (NOPS=2 and NOPS=3 instances).
module tb_dcpu16_opfetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start2, start3;
    logic [11:0] ea2;
    logic [17:0] ea3;
    logic [31:0] rrd2;
    logic [47:0] rrd3;
    logic [15:0] pc_in, sp_in, o_in;
    logic        fb_ack;
    logic [15:0] fb_dti;

    logic [15:0] adr2, adr3, pco2, pco3, spo2, spo3;
    logic        stb2, stb3, wre2, wre3, busy2, busy3, done2, done3;
    logic [31:0] opv2, opa2;
    logic [47:0] opv3, opa3;
    logic [1:0]  opm2;
    logic [2:0]  opm3;

    dcpu16_opfetch #(.DW(16), .AW(16), .NOPS(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .ea(ea2), .rrd(rrd2),
        .pc_in(pc_in), .sp_in(sp_in), .o_in(o_in),
        .fb_adr(adr2), .fb_stb(stb2), .fb_wre(wre2), .fb_dti(fb_dti), .fb_ack(fb_ack),
        .busy(busy2), .done(done2), .opv(opv2), .opa(opa2), .opm(opm2),
        .pc_out(pco2), .sp_out(spo2));

    dcpu16_opfetch #(.DW(16), .AW(16), .NOPS(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .ea(ea3), .rrd(rrd3),
        .pc_in(pc_in), .sp_in(sp_in), .o_in(o_in),
        .fb_adr(adr3), .fb_stb(stb3), .fb_wre(wre3), .fb_dti(fb_dti), .fb_ack(fb_ack),
        .busy(busy3), .done(done3), .opv(opv3), .opa(opa3), .opm(opm3),
        .pc_out(pco3), .sp_out(spo3));

    wire        stb_m = stb2 | stb3;
    wire [15:0] adr_m = stb3 ? adr3 : adr2;

    logic [15:0] mem [0:65535];
    int          wait_cyc = 0;
    int          cnt = 0;
    int          reads = 0;
    int          stall_err = 0;
    logic [15:0] last_adr = 16'h0;
    logic [15:0] prev_adr = 16'h0;
    logic        prev_stall = 1'b0;
    int          errors = 0;
    int          checks = 0;

    // Bus slave: ack after wait_cyc stalled cycles, watch address stability
    always @(negedge clk) begin
        if (stb_m && prev_stall && adr_m !== prev_adr) stall_err++;
        if (stb_m && cnt >= wait_cyc) begin
            fb_ack = 1'b1;
            fb_dti = mem[adr_m];
        end else begin
            fb_ack = 1'b0;
        end
        prev_stall = stb_m && !fb_ack;
        prev_adr   = adr_m;
    end

    // Transfer accounting at the active edge
    always @(posedge clk) begin
        if (stb_m && fb_ack) begin
            reads++;
            last_adr = adr_m;
            cnt = 0;
        end else if (stb_m) begin
            cnt++;
        end else begin
            cnt = 0;
        end
    end

    // Pulse start in cycle 0 and count cycles until done (bounded)
    task automatic run(input bit sel, input int maxc, output int cyc);
        @(posedge clk); #1;
        if (sel) start3 = 1'b1; else start2 = 1'b1;
        reads = 0;
        stall_err = 0;
        @(posedge clk); #1;
        start2 = 1'b0;
        start3 = 1'b0;
        cyc = 1;
        while (!(sel ? done3 : done2) && cyc < maxc) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (!(sel ? done3 : done2)) begin
            errors++;
            $display("FAIL timeout: done not seen after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy2); end
        checks++; if (stb2 !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b expected 0", stb2); end
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done2); end
        checks++; if (adr2 !== 16'h0) begin errors++; $display("FAIL rst_adr: got %h expected 0000", adr2); end
        checks++; if ({opv2, opa2, opm2} !== 66'h0) begin errors++; $display("FAIL rst_ops: got %h %h %b expected 0", opv2, opa2, opm2); end
        checks++; if ({pco2, spo2} !== 32'h0) begin errors++; $display("FAIL rst_pcsp: got %h %h expected 0", pco2, spo2); end
        checks++; if (wre2 !== 1'b0 || wre3 !== 1'b0) begin errors++; $display("FAIL rst_wre: got %b%b expected 00", wre2, wre3); end
        checks++; if (busy3 !== 1'b0 || stb3 !== 1'b0) begin errors++; $display("FAIL rst_u3: got busy=%b stb=%b expected 0", busy3, stb3); end
    endtask

    task automatic test_regs();
        int cyc;
        ea2 = {6'h01, 6'h00}; rrd2 = {16'h1111, 16'h2222};
        pc_in = 16'h1234; sp_in = 16'h5555; o_in = 16'h0000;
        run(1'b0, 20, cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL regs_lat: got %0d expected 3", cyc); end
        checks++; if (opv2 !== 32'h1111_2222) begin errors++; $display("FAIL regs_opv: got %h expected 11112222", opv2); end
        checks++; if (opm2 !== 2'b00 || opa2 !== 32'h0) begin errors++; $display("FAIL regs_opm: got %b %h expected 00 0", opm2, opa2); end
        checks++; if (pco2 !== 16'h1234 || spo2 !== 16'h5555) begin errors++; $display("FAIL regs_pcsp: got %h %h expected 1234 5555", pco2, spo2); end
        checks++; if (reads !== 0) begin errors++; $display("FAIL regs_bus: got %0d reads expected 0", reads); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL regs_busyfin: got %b expected 1", busy2); end
        ea2 = 12'h0; rrd2 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL regs_pulse: got done=%b busy=%b expected 0 0", done2, busy2); end
        checks++; if (opv2 !== 32'h1111_2222) begin errors++; $display("FAIL regs_hold: got %h expected 11112222", opv2); end
    endtask

    task automatic test_nextword_lit();
        int cyc;
        ea2 = {6'h25, 6'h1f}; rrd2 = 32'h0;
        pc_in = 16'h0100; sp_in = 16'h0000;
        mem[16'h0100] = 16'hBEEF;
        wait_cyc = 0;
        run(1'b0, 20, cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL nw_lat: got %0d expected 4", cyc); end
        checks++; if (reads !== 1 || last_adr !== 16'h0100) begin errors++; $display("FAIL nw_bus: got %0d reads at %h expected 1 at 0100", reads, last_adr); end
        checks++; if (opv2 !== 32'h0005_BEEF) begin errors++; $display("FAIL nw_opv: got %h expected 0005beef", opv2); end
        checks++; if (pco2 !== 16'h0101 || opm2 !== 2'b00) begin errors++; $display("FAIL nw_pc: got %h %b expected 0101 00", pco2, opm2); end
    endtask

    task automatic test_indirect_stall();
        int cyc;
        ea2 = {6'h00, 6'h10}; rrd2 = {16'h7777, 16'h0003};
        pc_in = 16'h0200; sp_in = 16'h0000;
        mem[16'h0200] = 16'h0040;
        mem[16'h0043] = 16'h1234;
        wait_cyc = 3;
        run(1'b0, 40, cyc);
        wait_cyc = 0;
        checks++; if (cyc !== 11) begin errors++; $display("FAIL ind_lat: got %0d expected 11", cyc); end
        checks++; if (reads !== 2 || last_adr !== 16'h0043) begin errors++; $display("FAIL ind_bus: got %0d reads last %h expected 2 last 0043", reads, last_adr); end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL ind_stable: got %0d address changes expected 0", stall_err); end
        checks++; if (opv2 !== 32'h7777_1234) begin errors++; $display("FAIL ind_opv: got %h expected 77771234", opv2); end
        checks++; if (opa2 !== 32'h0000_0043 || opm2 !== 2'b01) begin errors++; $display("FAIL ind_opa: got %h %b expected 00000043 01", opa2, opm2); end
        checks++; if (pco2 !== 16'h0201) begin errors++; $display("FAIL ind_pc: got %h expected 0201", pco2); end
    endtask

    task automatic test_push_pop();
        int cyc;
        ea2 = {6'h18, 6'h1a}; rrd2 = 32'h0;
        pc_in = 16'h0400; sp_in = 16'h0000;
        mem[16'hFFFF] = 16'hCAFE;
        run(1'b0, 20, cyc);
        checks++; if (reads !== 2 || last_adr !== 16'hFFFF) begin errors++; $display("FAIL pp_bus: got %0d reads last %h expected 2 last ffff", reads, last_adr); end
        checks++; if (opv2 !== 32'hCAFE_CAFE) begin errors++; $display("FAIL pp_opv: got %h expected cafecafe", opv2); end
        checks++; if (opa2 !== 32'hFFFF_FFFF || opm2 !== 2'b11) begin errors++; $display("FAIL pp_opa: got %h %b expected ffffffff 11", opa2, opm2); end
        checks++; if (spo2 !== 16'h0000 || pco2 !== 16'h0400) begin errors++; $display("FAIL pp_sp: got sp=%h pc=%h expected 0000 0400", spo2, pco2); end
    endtask

    task automatic test_reset_midfetch();
        bit saw_done;
        ea2 = {6'h00, 6'h1e}; rrd2 = 32'h0;
        pc_in = 16'h0500; sp_in = 16'h0000;
        wait_cyc = 3;
        @(posedge clk); #1; start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        @(posedge clk); #1;
        checks++; if (stb2 !== 1'b1 || adr2 !== 16'h0500) begin errors++; $display("FAIL mid_nwrd: got stb=%b adr=%h expected 1 0500", stb2, adr2); end
        start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        checks++; if (busy2 !== 1'b1 || stb2 !== 1'b1 || adr2 !== 16'h0500) begin errors++; $display("FAIL mid_ignore: got busy=%b stb=%b adr=%h expected 1 1 0500", busy2, stb2, adr2); end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checks++; if (stb2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL mid_rst: got stb=%b busy=%b expected 0 0", stb2, busy2); end
        checks++; if (opv2 !== 32'h0 || opm2 !== 2'b00) begin errors++; $display("FAIL mid_clear: got %h %b expected 0 00", opv2, opm2); end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done2 || busy2) saw_done = 1'b1;
        end
        wait_cyc = 0;
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_nodone: got activity=%b expected 0", saw_done); end
    endtask

    task automatic test_three_ops();
        int cyc;
        ea3 = {6'h1c, 6'h1f, 6'h1d}; rrd3 = 48'h0;
        pc_in = 16'h0300; sp_in = 16'h0000; o_in = 16'h00AA;
        mem[16'h0300] = 16'h5A5A;
        run(1'b1, 20, cyc);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL n3_lat: got %0d expected 5", cyc); end
        checks++; if (opv3 !== 48'h0301_5A5A_00AA) begin errors++; $display("FAIL n3_opv: got %h expected 03015a5a00aa", opv3); end
        checks++; if (pco3 !== 16'h0301 || opm3 !== 3'b000) begin errors++; $display("FAIL n3_pc: got %h %b expected 0301 000", pco3, opm3); end
    endtask

    task automatic test_sp_literal();
        int cyc;
        ea2 = {6'h3f, 6'h1b}; rrd2 = 32'hFFFF_FFFF;
        pc_in = 16'h0600; sp_in = 16'hABCD; o_in = 16'h0000;
        run(1'b0, 20, cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL spl_lat: got %0d expected 3", cyc); end
        checks++; if (opv2 !== 32'h001F_ABCD) begin errors++; $display("FAIL spl_opv: got %h expected 001fabcd", opv2); end
        checks++; if (spo2 !== 16'hABCD || reads !== 0) begin errors++; $display("FAIL spl_sp: got %h reads=%0d expected abcd 0", spo2, reads); end
    endtask

    initial begin
        start2 = 1'b0; start3 = 1'b0;
        ea2 = '0; ea3 = '0; rrd2 = '0; rrd3 = '0;
        pc_in = '0; sp_in = '0; o_in = '0;
        fb_ack = 1'b0; fb_dti = '0;
        test_reset();
        test_regs();
        test_nextword_lit();
        test_indirect_stall();
        test_push_pop();
        test_reset_midfetch();
        test_three_ops();
        test_sp_literal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcpu16_opfetch.md
# dcpu16_opfetch

Parametrised operand fetch unit for the DCPU16 core: it decodes NOPS 6-bit operand specifiers, performs every needed next-word and memory read over a handshaked read-only bus, and returns the operand values, their effective addresses and the updated PC/SP. It sits between the decode stage and the ALU/write-back stage. Unlike the earlier two-phase A/B loader, it waits on bus acknowledge, supports any operand count, and owns PC/SP side effects (next-word increment, POP/PUSH).

## Interface
- DW, 16, data width; must be ≥ 6
- AW, 16, address width
- NOPS, 2, operands per instruction (1..4); operand 0 is fetched first

Reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin fetch; sampled only when busy=0
- ea  in  6*NOPS  operand specifiers, operand k at [6k+5:6k]
- rrd  in  DW*NOPS  register-file values selected by ea[2:0] of each operand
- pc_in, sp_in  in  AW  architectural PC (already past opcode word) and SP
- o_in  in  DW  overflow register O
- fb_adr  out  AW  bus address
- fb_stb  out  1  bus request
- fb_wre  out  1  constant 0
- fb_dti  in  DW  read data, valid when fb_ack=1
- fb_ack  in  1  transfer complete
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse, all outputs below valid
- opv  out  DW*NOPS  operand values
- opa  out  AW*NOPS  effective address per operand (0 for non-memory operands)
- opm  out  NOPS  1 = operand k is a memory location (write-back target)
- pc_out, sp_out  out  AW  updated PC/SP, valid with done

## Operation
- States: IDLE, DECODE, NWRD, MEM, FIN. Index k counts operands.
- IDLE: start=1 latches ea, rrd, pc_in, sp_in, o_in into working regs (pc, sp); k←0; → DECODE. start while busy is ignored.
- DECODE on ea_k:
  - 0x00-07: opv_k←rrd_k, opm_k←0.
  - 0x08-0x0f: adr←rrd_k[AW-1:0] → MEM.
  - 0x10-0x17, 0x1e, 0x1f: → NWRD (adr←pc).
  - 0x18 POP: adr←sp, sp←sp+1 → MEM. 0x19 PEEK: adr←sp → MEM. 0x1a PUSH: sp←sp−1, adr←sp−1 → MEM.
  - 0x1b: opv_k←sp zero-extended. 0x1c: opv_k←pc (current working PC). 0x1d: opv_k←o_in.
  - 0x20-0x3f: opv_k←ea_k−0x20, zero-extended.
  - Direct cases advance: k←k+1, or → FIN when k=NOPS−1.
- NWRD: on ack, pc←pc+1; 0x1f: opv_k←fb_dti, opm_k←0, advance; 0x1e: adr←fb_dti → MEM; 0x10-17: adr←fb_dti+rrd_k → MEM.
- MEM: on ack opv_k←fb_dti, opa_k←adr, opm_k←1, advance.
- FIN: done=1, pc_out←pc, sp_out←sp; → IDLE.
- Address arithmetic modulo 2^AW; sp/pc wrap 0xFFFF↔0x0000 silently. Data truncation/zero-extension between DW and AW.

## Timing
- Reset: state IDLE, fb_adr=0, fb_stb=0, busy=0, done=0, opv=0, opa=0, opm=0, pc_out=0, sp_out=0.
- busy=1 from the cycle after start through FIN inclusive.
- fb_stb is registered: high exactly while in NWRD/MEM; fb_adr stable while fb_stb=1. Transfer completes in any cycle with fb_stb=1 and fb_ack=1 (zero-wait ack allowed, 1 cycle/access); fb_stb drops or re-issues a new address the next cycle. fb_ack with fb_stb=0 ignored.
- Latency (zero-wait bus): start in cycle 0; 1 cycle per operand DECODE, +1 per NWRD, +1 per MEM, +1 FIN. Two register operands: done in cycle 3.
- opv/opa/opm/pc_out/sp_out hold until the next done.
- rst mid-fetch: state returns to IDLE and fb_stb=0 in the following cycle; no done, partial results cleared.

## Test plan
- NOPS=2, ea={0x01,0x00}, rrd={0x1111,0x2222}, start at cycle 0 → done in cycle 3, opv={0x1111,0x2222}, opm=0, pc_out=pc_in, no fb_stb.
- ea0=0x1f, ea1=0x25, pc_in=0x0100, mem[0x0100]=0xBEEF, zero-wait → one read at 0x0100, opv0=0xBEEF, opv1=0x0005, pc_out=0x0101, done in cycle 4.
- ea0=0x10, rrd0=0x0003, mem[0x0200]=0x0040, mem[0x0043]=0x1234, pc_in=0x0200, ack delayed 3 cycles each → fb_adr stable while stalled, opv0=0x1234, opa0=0x0043, opm0=1, pc_out=0x0201.
- sp_in=0x0000, ea0=0x1a PUSH, ea1=0x18 POP → PUSH reads 0xFFFF, POP reads 0xFFFF, sp_out=0x0000.
- ea0=0x1e, second start pulse while busy, then rst asserted during NWRD stall → start ignored, fb_stb=0 and busy=0 cycle after rst, no done.
- NOPS=3, DW=AW=16, ea={0x1c,0x1f,0x1d} → opv2 equals pc_in+1 (PC after next-word), opv1 next word, opv0=o_in.
